// File: rtl/pgm_pkg.sv
// Shared constants and helpers for the PGM sound-reply mailbox: Z80 reply ports,
// 68k register offsets, the 68k base address and the STATUS word layout.
package pgm_pkg;

  localparam logic [7:0]  Z_PORT_L1 = 8'h82;
  localparam logic [7:0]  Z_PORT_L2 = 8'h84;
  localparam logic [7:0]  Z_PORT_L3 = 8'h81;

  localparam logic [3:0]  OFF_L1     = 4'h2;
  localparam logic [3:0]  OFF_L2     = 4'h4;
  localparam logic [3:0]  OFF_STATUS = 4'h6;
  localparam logic [3:0]  OFF_L3     = 4'hC;

  localparam logic [19:0] M_BASE = 20'hC0000;

  localparam int STAT_FULL_LSB = 0;
  localparam int STAT_OVR_LSB  = 4;

  localparam logic [15:0] M_IDLE_DATA = 16'hFFFF;

  typedef enum logic [2:0] {
    RD_NONE,
    RD_L1,
    RD_L2,
    RD_L3,
    RD_STATUS
  } rd_sel_e;

  // Bit i of the result selects latch L(i+1); unmapped ports give zero.
  function automatic logic [2:0] port_onehot(input logic [7:0] port);
    logic [2:0] sel;
    sel = 3'b000;
    case (port)
      Z_PORT_L1: sel = 3'b001;
      Z_PORT_L2: sel = 3'b010;
      Z_PORT_L3: sel = 3'b100;
      default:   sel = 3'b000;
    endcase
    return sel;
  endfunction

  function automatic logic [15:0] status_word(input logic [2:0] full, input logic [2:0] ovr);
    logic [15:0] w;
    w = '0;
    w[STAT_FULL_LSB +: 3] = full;
    w[STAT_OVR_LSB  +: 3] = ovr;
    return w;
  endfunction

endpackage

// File: rtl/pgm_sync2.sv
// Parameterised-width, STAGES-deep flop synchroniser with synchronous reset;
// carries an asynchronous bundle into the fixed_20m_clk domain.
module pgm_sync2 #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             fixed_20m_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the value its predecessor held before this edge.
  always_ff @(posedge fixed_20m_clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/pgm_sound_reply_mailbox.sv
// PGM sound-latch return path: Z80 writes three reply latches, the 68k reads them
// plus a STATUS word. Optional reply-pending IRQ under `PGM_SNDREPLY_IRQ_EN.
import pgm_pkg::*;

module pgm_sound_reply_mailbox #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        fixed_20m_clk,
  input  logic        reset,
  input  logic        z_iorq_n,
  input  logic        z_wr_n,
  input  logic [7:0]  z_port,
  input  logic [7:0]  z_data,
  input  logic [23:1] m_adr,
  input  logic        m_as_n,
  input  logic        m_rw_n,
  output logic [15:0] m_dout,
  output logic        m_dtack_n
`ifdef PGM_SNDREPLY_IRQ_EN
  ,
  output logic        m_irq
`endif
);

  logic                   zstb_s, zstb_hist, capture;
  logic [7:0]             port_s, data_s;
  logic [SYNC_STAGES-1:0] fill;
  logic [2:0]             cap_hit, rd_clr, full, ovr;
  logic [7:0]             latch [3];
  logic                   as_hist, m_start, stat_clr;
  logic [3:0]             offset;
  rd_sel_e                rd_sel;
  logic [15:0]            rd_data;

  pgm_sync2 #(.WIDTH(17), .STAGES(SYNC_STAGES)) u_sync (
    .fixed_20m_clk (fixed_20m_clk),
    .reset         (reset),
    .d             ({!z_iorq_n && !z_wr_n, z_port, z_data}),
    .q             ({zstb_s, port_s, data_s})
  );

  // History is held at 1 until the synchroniser holds post-reset samples, so a
  // strobe already high at reset release never looks like a rising edge.
  always_ff @(posedge fixed_20m_clk) begin
    if (reset) begin
      fill      <= '0;
      zstb_hist <= 1'b1;
      as_hist   <= 1'b1;
    end else begin
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
      zstb_hist <= fill[SYNC_STAGES-1] ? zstb_s : 1'b1;
      as_hist   <= m_as_n;
    end
  end

  assign capture = zstb_s && !zstb_hist;
  assign cap_hit = capture ? port_onehot(port_s) : 3'b000;
  assign offset  = {m_adr[3:1], 1'b0};
  assign m_start = !m_as_n && as_hist;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_sel = RD_NONE;
    if (m_adr[23:4] == M_BASE && m_rw_n) begin
      case (offset)
        OFF_L1:     rd_sel = RD_L1;
        OFF_L2:     rd_sel = RD_L2;
        OFF_L3:     rd_sel = RD_L3;
        OFF_STATUS: rd_sel = RD_STATUS;
        default:    rd_sel = RD_NONE;
      endcase
    end
  end

  always_comb begin
    rd_data = M_IDLE_DATA;
    case (rd_sel)
      RD_L1:     rd_data = {8'h00, latch[0]};
      RD_L2:     rd_data = {8'h00, latch[1]};
      RD_L3:     rd_data = {8'h00, latch[2]};
      RD_STATUS: rd_data = status_word(full, ovr);
      default:   rd_data = M_IDLE_DATA;
    endcase
  end

  assign rd_clr   = m_start ? {rd_sel == RD_L3, rd_sel == RD_L2, rd_sel == RD_L1} : 3'b000;
  assign stat_clr = m_start && (rd_sel == RD_STATUS);

  // A capture overrides a same-cycle read clear; ovr looks at full before this edge.
  // NOTE: the three reply latches are explicitly reset since software may read
  // them before the Z80 has written anything.
  always_ff @(posedge fixed_20m_clk) begin
    if (reset) begin
      full <= '0;
      ovr  <= '0;
      for (int i = 0; i < 3; i++) latch[i] <= 8'h00;
    end else begin
      full <= (full & ~rd_clr) | cap_hit;
      ovr  <= (stat_clr ? 3'b000 : ovr) | (cap_hit & full);
      for (int i = 0; i < 3; i++) if (cap_hit[i]) latch[i] <= data_s;
    end
  end

  // Read data is snapshotted at access start and held until the strobe rises.
  always_ff @(posedge fixed_20m_clk) begin
    if (reset || m_as_n) begin
      m_dout    <= M_IDLE_DATA;
      m_dtack_n <= 1'b1;
    end else if (m_start && rd_sel != RD_NONE) begin
      m_dout    <= rd_data;
      m_dtack_n <= 1'b0;
    end
  end

`ifdef PGM_SNDREPLY_IRQ_EN
  always_ff @(posedge fixed_20m_clk) begin
    if (reset) m_irq <= 1'b0;
    else       m_irq <= |full;
  end
`endif

endmodule

// File: tb/tb_pgm_sound_reply_mailbox.sv
// Directed bench for pgm_sound_reply_mailbox: a table of Z80 writes and 68k
// accesses with hand-computed results, plus collision and reset sequences.
module tb_pgm_sound_reply_mailbox;

  logic        fixed_20m_clk = 1'b0;
  logic        reset = 1'b1;
  logic        z_iorq_n = 1'b1, z_wr_n = 1'b1;
  logic [7:0]  z_port = 8'h00, z_data = 8'h00;
  logic [23:1] m_adr = '0;
  logic        m_as_n = 1'b1, m_rw_n = 1'b1;
  logic [15:0] m_dout;
  logic        m_dtack_n;
`ifdef PGM_SNDREPLY_IRQ_EN
  logic        m_irq;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  pgm_sound_reply_mailbox #(.SYNC_STAGES(2)) dut (
    .fixed_20m_clk (fixed_20m_clk),
    .reset         (reset),
    .z_iorq_n      (z_iorq_n),
    .z_wr_n        (z_wr_n),
    .z_port        (z_port),
    .z_data        (z_data),
    .m_adr         (m_adr),
    .m_as_n        (m_as_n),
    .m_rw_n        (m_rw_n),
    .m_dout        (m_dout),
    .m_dtack_n     (m_dtack_n)
`ifdef PGM_SNDREPLY_IRQ_EN
    ,
    .m_irq         (m_irq)
`endif
  );

  always #25 fixed_20m_clk = ~fixed_20m_clk;

  typedef struct {
    bit          is_z;
    logic [7:0]  port;
    logic [7:0]  data;
    logic [23:0] addr;
    bit          rw_n;
    logic [15:0] exp_dout;
    logic        exp_dtack_n;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk_z(input logic [7:0] port, input logic [7:0] data);
    vec_t v;
    v = '{1'b1, port, data, 24'h0, 1'b1, 16'h0, 1'b1};
    return v;
  endfunction

  function automatic vec_t mk_m(input logic [23:0] addr, input bit rw_n,
                                input logic [15:0] exp_dout, input logic exp_dtack_n);
    vec_t v;
    v = '{1'b0, 8'h00, 8'h00, addr, rw_n, exp_dout, exp_dtack_n};
    return v;
  endfunction

  task automatic tick();
    @(posedge fixed_20m_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic z_out(input logic [7:0] port, input logic [7:0] data, input int cycles);
    z_port = port;
    z_data = data;
    z_iorq_n = 1'b0;
    z_wr_n = 1'b0;
    repeat (cycles) tick();
    z_iorq_n = 1'b1;
    z_wr_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic m_access(input string tag, input logic [23:0] addr, input bit rw_n,
                          input logic [15:0] exp_dout, input logic exp_dtack_n);
    m_adr = addr[23:1];
    m_rw_n = rw_n;
    m_as_n = 1'b0;
    tick();
    check({tag, " dout"}, {16'h0, m_dout}, {16'h0, exp_dout});
    check({tag, " dtack_n"}, {31'h0, m_dtack_n}, {31'h0, exp_dtack_n});
    tick();
    check({tag, " hold dout"}, {16'h0, m_dout}, {16'h0, exp_dout});
    m_as_n = 1'b1;
    m_rw_n = 1'b1;
    tick();
    check({tag, " release dout"}, {16'h0, m_dout}, 32'h0000_FFFF);
    check({tag, " release dtack_n"}, {31'h0, m_dtack_n}, 32'h1);
  endtask

  initial begin
    vq.push_back(mk_m(24'hC00006, 1'b1, 16'h0000, 1'b0));
    vq.push_back(mk_m(24'hC00002, 1'b1, 16'h0000, 1'b0));
    vq.push_back(mk_z(8'h82, 8'h5A));
    vq.push_back(mk_m(24'hC00002, 1'b1, 16'h005A, 1'b0));
    vq.push_back(mk_m(24'hC00006, 1'b1, 16'h0000, 1'b0));
    vq.push_back(mk_z(8'h84, 8'h11));
    vq.push_back(mk_z(8'h84, 8'h22));
    vq.push_back(mk_m(24'hC00006, 1'b1, 16'h0022, 1'b0));
    vq.push_back(mk_m(24'hC00006, 1'b1, 16'h0002, 1'b0));
    vq.push_back(mk_m(24'hC00004, 1'b1, 16'h0022, 1'b0));
    vq.push_back(mk_m(24'hC00006, 1'b1, 16'h0000, 1'b0));
    vq.push_back(mk_z(8'h81, 8'h77));
    vq.push_back(mk_m(24'hC0000C, 1'b1, 16'h0077, 1'b0));
    vq.push_back(mk_m(24'hC00006, 1'b1, 16'h0000, 1'b0));
    vq.push_back(mk_z(8'h99, 8'hEE));
    vq.push_back(mk_m(24'hC00006, 1'b1, 16'h0000, 1'b0));
    vq.push_back(mk_m(24'hC00002, 1'b1, 16'h005A, 1'b0));
    vq.push_back(mk_z(8'h82, 8'hAB));
    vq.push_back(mk_m(24'hC00002, 1'b0, 16'hFFFF, 1'b1));
    vq.push_back(mk_m(24'hC00008, 1'b1, 16'hFFFF, 1'b1));
    vq.push_back(mk_m(24'hC10002, 1'b1, 16'hFFFF, 1'b1));
    vq.push_back(mk_m(24'hC00006, 1'b1, 16'h0001, 1'b0));
    vq.push_back(mk_m(24'hC00002, 1'b1, 16'h00AB, 1'b0));
    vq.push_back(mk_m(24'hC00006, 1'b1, 16'h0000, 1'b0));

    repeat (3) tick();
    check("reset dout", {16'h0, m_dout}, 32'h0000_FFFF);
    check("reset dtack_n", {31'h0, m_dtack_n}, 32'h1);
    reset = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].is_z) z_out(vq[i].port, vq[i].data, 8);
      else m_access($sformatf("vec%0d", i), vq[i].addr, vq[i].rw_n,
                    vq[i].exp_dout, vq[i].exp_dtack_n);
    end

    // Z80 capture of 0x81=0x33 lands on the access-start cycle of a C0000C read.
    z_out(8'h81, 8'h77, 7);
    z_port = 8'h81;
    z_data = 8'h33;
    z_iorq_n = 1'b0;
    z_wr_n = 1'b0;
    tick();
    tick();
    m_adr = 23'(24'hC0000C >> 1);
    m_rw_n = 1'b1;
    m_as_n = 1'b0;
    tick();
    check("collide dout", {16'h0, m_dout}, 32'h0000_0077);
    check("collide dtack_n", {31'h0, m_dtack_n}, 32'h0);
    repeat (5) tick();
    z_iorq_n = 1'b1;
    z_wr_n = 1'b1;
    m_as_n = 1'b1;
    repeat (4) tick();
    m_access("collide status", 24'hC00006, 1'b1, 16'h0044, 1'b0);
    m_access("collide L3 new", 24'hC0000C, 1'b1, 16'h0033, 1'b0);
    m_access("collide status clr", 24'hC00006, 1'b1, 16'h0000, 1'b0);

    // A strobe held across reset release must be dropped.
    reset = 1'b1;
    z_port = 8'h82;
    z_data = 8'hC5;
    z_iorq_n = 1'b0;
    z_wr_n = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (8) tick();
    z_iorq_n = 1'b1;
    z_wr_n = 1'b1;
    repeat (4) tick();
`ifdef PGM_SNDREPLY_IRQ_EN
    check("drop irq", {31'h0, m_irq}, 32'h0);
`endif
    m_access("drop status", 24'hC00006, 1'b1, 16'h0000, 1'b0);
    m_access("drop L1", 24'hC00002, 1'b1, 16'h0000, 1'b0);
    m_access("drop L3", 24'hC0000C, 1'b1, 16'h0000, 1'b0);

    z_out(8'h82, 8'h3C, 7);
`ifdef PGM_SNDREPLY_IRQ_EN
    check("irq set", {31'h0, m_irq}, 32'h1);
`endif
    m_access("post reset L1", 24'hC00002, 1'b1, 16'h003C, 1'b0);
`ifdef PGM_SNDREPLY_IRQ_EN
    check("irq clear", {31'h0, m_irq}, 32'h0);
`endif

    // Reset asserted in the middle of an access.
    m_adr = 23'(24'hC00002 >> 1);
    m_rw_n = 1'b1;
    m_as_n = 1'b0;
    tick();
    check("mid dtack_n", {31'h0, m_dtack_n}, 32'h0);
    check("mid dout", {16'h0, m_dout}, 32'h0000_003C);
    reset = 1'b1;
    tick();
    check("mid reset dout", {16'h0, m_dout}, 32'h0000_FFFF);
    check("mid reset dtack_n", {31'h0, m_dtack_n}, 32'h1);
    m_as_n = 1'b1;
    reset = 1'b0;
    repeat (3) tick();
    m_access("mid reset L1", 24'hC00002, 1'b1, 16'h0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
